// File: rtl/frequency_meter_pkg.sv
// Shared definitions for the frequency meter.
// Contents:
//   fm_state_e  - FSM state encoding (idle, measuring, reporting)
//   gate_width  - width of the gate counter for a given window length
package frequency_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_REPORT  = 2'd2
    } fm_state_e;

    // Bits needed to hold 0 .. gate_cycles-1; never less than one bit.
    function automatic int gate_width(input int gate_cycles);
        if (gate_cycles <= 2) begin
            return 1;
        end else begin
            return $clog2(gate_cycles);
        end
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus history flop with rising-edge detect.
// Reusable for any slow asynchronous input (buttons, switches, test clocks).
// Ports:
//   clk  - sampling clock
//   rst  - asynchronous active-high reset
//   din  - asynchronous input
//   rise - one-cycle pulse, high when the synchronized input went 0 -> 1
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Synchronizer chain (s1, s2) followed by the history flop s3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= din;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign rise = s2_r & ~s3_r;

endmodule

// File: rtl/frequency_meter.sv
// Frequency meter: counts rising edges of an asynchronous input over a
// window of GATE_CYCLES clk cycles and publishes the result.
// Parameters:
//   GATE_CYCLES - window length in clk cycles (>= 2)
//   CNT_WIDTH   - width of the edge counter and of count
// Ports:
//   clk         - board clock
//   rst         - asynchronous active-high reset
//   enable      - 1 = measure continuously, 0 = stop
//   sig_in      - asynchronous signal under measurement
//   count       - edges counted in the last completed window
//   count_valid - one-cycle pulse when count/overflow update
//   overflow    - last completed window saturated the edge counter
//   busy        - high while a window is being measured
module frequency_meter
    import frequency_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 1000000,
    parameter int CNT_WIDTH   = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 count_valid,
    output logic                 overflow,
    output logic                 busy
);

    localparam int GW = gate_width(GATE_CYCLES);
    localparam logic [GW-1:0]        GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [GW-1:0]        GATE_ONE  = GW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    fm_state_e              state_r;
    fm_state_e              next_state_s;
    logic                   clear_s;
    logic                   run_s;
    logic                   load_s;
    logic                   rise_s;
    logic [GW-1:0]          gate_r;
    logic [CNT_WIDTH-1:0]   edge_r;
    logic                   ovf_r;
    logic [CNT_WIDTH-1:0]   edge_next_s;
    logic                   ovf_next_s;
    logic [CNT_WIDTH-1:0]   count_r;
    logic                   count_valid_r;
    logic                   overflow_r;
    logic                   busy_r;

    sync_edge_detect u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sig_in),
        .rise (rise_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and datapath control strobes.
    always_comb begin
        next_state_s = state_r;
        clear_s      = 1'b0;
        run_s        = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    clear_s      = 1'b1;
                    next_state_s = ST_MEASURE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                // Abort wins over window end: a dropped enable never reports.
                if (!enable) begin
                    next_state_s = ST_IDLE;
                end else begin
                    run_s = 1'b1;
                    if (gate_r == GATE_LAST) begin
                        load_s       = 1'b1;
                        next_state_s = ST_REPORT;
                    end else begin
                        next_state_s = ST_MEASURE;
                    end
                end
            end
            ST_REPORT: begin
                // Clearing here also drops any edge seen in this cycle.
                clear_s = 1'b1;
                if (enable) begin
                    next_state_s = ST_MEASURE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Saturating edge increment; overflow marks an edge lost at full scale.
    always_comb begin
        edge_next_s = edge_r;
        ovf_next_s  = ovf_r;
        if (rise_s) begin
            if (edge_r == CNT_MAX) begin
                ovf_next_s = 1'b1;
            end else begin
                edge_next_s = edge_r + CNT_ONE;
            end
        end else begin
            edge_next_s = edge_r;
        end
    end

    // Gate counter, edge counter and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_r <= {GW{1'b0}};
            edge_r <= {CNT_WIDTH{1'b0}};
            ovf_r  <= 1'b0;
        end else if (clear_s) begin
            gate_r <= {GW{1'b0}};
            edge_r <= {CNT_WIDTH{1'b0}};
            ovf_r  <= 1'b0;
        end else if (run_s) begin
            gate_r <= gate_r + GATE_ONE;
            edge_r <= edge_next_s;
            ovf_r  <= ovf_next_s;
        end else begin
            gate_r <= gate_r;
            edge_r <= edge_r;
            ovf_r  <= ovf_r;
        end
    end

    // Result registers load on the last measure cycle, including that
    // cycle's edge, so they and the valid pulse appear during REPORT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r       <= {CNT_WIDTH{1'b0}};
            overflow_r    <= 1'b0;
            count_valid_r <= 1'b0;
        end else begin
            count_valid_r <= load_s;
            if (load_s) begin
                count_r    <= edge_next_s;
                overflow_r <= ovf_next_s;
            end else begin
                count_r    <= count_r;
                overflow_r <= overflow_r;
            end
        end
    end

    // Registered busy flag, high exactly during MEASURE cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s == ST_MEASURE);
        end
    end

    assign count       = count_r;
    assign count_valid = count_valid_r;
    assign overflow    = overflow_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_frequency_meter.sv
// Directed testbench for frequency_meter with GATE_CYCLES = 100.
// Two instances share clk/rst/enable: a 24-bit one driven by sig_a and a
// 4-bit one driven by sig_b for the saturation scenario.
module tb_frequency_meter;

    localparam int G = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        sig_a;
    logic        sig_b;
    logic [23:0] count;
    logic        count_valid;
    logic        overflow;
    logic        busy;
    logic [3:0]  count4;
    logic        count_valid4;
    logic        overflow4;
    logic        busy4;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   half_a  = 0;
    int   half_b  = 0;
    logic level_a = 1'b0;
    logic level_b = 1'b0;

    frequency_meter #(.GATE_CYCLES(G), .CNT_WIDTH(24)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .sig_in      (sig_a),
        .count       (count),
        .count_valid (count_valid),
        .overflow    (overflow),
        .busy        (busy)
    );

    frequency_meter #(.GATE_CYCLES(G), .CNT_WIDTH(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .sig_in      (sig_b),
        .count       (count4),
        .count_valid (count_valid4),
        .overflow    (overflow4),
        .busy        (busy4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until count_valid is seen; lat = cycles waited.
    task automatic wait_valid(input int budget, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!count_valid && lat < budget);
        check("valid_seen", 32'(count_valid), 32'd1);
    endtask

    // Square-wave / level generators, updated 2 ns after each clock edge.
    initial begin
        int ph_a;
        int ph_b;
        ph_a  = 0;
        ph_b  = 0;
        sig_a = 1'b0;
        sig_b = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (half_a > 0) begin
                ph_a++;
                if (ph_a >= half_a) begin
                    ph_a  = 0;
                    sig_a = ~sig_a;
                end
            end else begin
                sig_a = level_a;
            end
            if (half_b > 0) begin
                ph_b++;
                if (ph_b >= half_b) begin
                    ph_b  = 0;
                    sig_b = ~sig_b;
                end
            end else begin
                sig_b = level_b;
            end
        end
    end

    initial begin
        int lat;
        int seen;
        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) tick();
        check("rst_count",    32'(count), 32'd0);
        check("rst_valid",    32'(count_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_count4",   32'(count4), 32'd0);

        // Idle with waves running: nothing happens.
        rst    = 1'b0;
        half_a = 5;
        half_b = 2;
        repeat (20) tick();
        check("idle_busy",  32'(busy), 32'd0);
        check("idle_valid", 32'(count_valid), 32'd0);

        // Window 1: period-10 wave -> 10 edges; period-4 into 4 bits saturates.
        enable = 1'b1;
        wait_valid(300, lat);
        check("first_latency", 32'(lat), 32'd101);
        check("w1_count",      32'(count), 32'd10);
        check("w1_overflow",   32'(overflow), 32'd0);
        check("w1_valid4",     32'(count_valid4), 32'd1);
        check("w1_count4",     32'(count4), 32'd15);
        check("w1_overflow4",  32'(overflow4), 32'd1);
        half_b  = 0;
        level_b = 1'b0;
        tick();
        check("valid_one_cycle", 32'(count_valid), 32'd0);
        check("count_hold",      32'(count), 32'd10);
        check("busy_next_win",   32'(busy), 32'd1);

        // Window 2: spacing between reports.
        wait_valid(300, lat);
        check("valid_period", 32'(lat + 1), 32'd101);
        check("w2_count",     32'(count), 32'd10);

        // Window 3: sig_a stops; 4-bit instance sees a quiet window.
        half_a  = 0;
        level_a = 1'b0;
        wait_valid(300, lat);
        check("w3_count4",    32'(count4), 32'd0);
        check("w3_overflow4", 32'(overflow4), 32'd0);

        // Window 4: single rise mid-window; window 5: held high.
        repeat (50) tick();
        level_a = 1'b1;
        wait_valid(300, lat);
        check("w4_count",    32'(count), 32'd1);
        check("w4_overflow", 32'(overflow), 32'd0);
        wait_valid(300, lat);
        check("w5_count", 32'(count), 32'd0);

        // Windows 6-7: restart wave; window 7 is fully periodic.
        half_a = 5;
        wait_valid(300, lat);
        wait_valid(300, lat);
        check("w7_count", 32'(count), 32'd10);

        // Abort 50 cycles into window 8.
        repeat (50) tick();
        check("abort_busy_before", 32'(busy), 32'd1);
        enable = 1'b0;
        tick();
        check("abort_busy_after", 32'(busy), 32'd0);
        seen = 0;
        repeat (150) begin
            tick();
            if (count_valid) seen++;
        end
        check("abort_no_valid",   32'(seen), 32'd0);
        check("abort_count_hold", 32'(count), 32'd10);
        check("abort_busy_idle",  32'(busy), 32'd0);

        // Reset 30 cycles into a window.
        enable = 1'b1;
        repeat (30) tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_busy",  32'(busy), 32'd0);
        check("midrst_valid", 32'(count_valid), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        wait_valid(300, lat);
        check("rst_restart_latency", 32'(lat), 32'd101);
        check("rst_restart_count", 32'(count >= 24'd9 && count <= 24'd11), 32'd1);

        // One-cycle pulses: 5 applied inside one window.
        half_a  = 0;
        level_a = 1'b0;
        wait_valid(300, lat);
        repeat (10) tick();
        repeat (5) begin
            level_a = 1'b1;
            tick();
            level_a = 1'b0;
            repeat (5) tick();
        end
        wait_valid(300, lat);
        check("pulse_no_x",   32'($isunknown(count)), 32'd0);
        check("pulse_le_5",   32'(count <= 24'd5), 32'd1);
        check("pulse_no_x4",  32'($isunknown(count4)), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
